// File: rtl/capture_sequencer.sv
// Logic-analyser capture controller: SPI command parser, sample divider, pattern
// trigger, sample RAM writer and buffer readout through the SPI transmit register.
module capture_sequencer #(
   parameter int ADDR_W = 9,
   parameter int DIV_W  = 16
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [7:0]        pin_values,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_byte,
   output logic              tx_load,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   localparam logic [7:0] OP_SET_DIV  = 8'h01;
   localparam logic [7:0] OP_SET_TRIG = 8'h02;
   localparam logic [7:0] OP_ARM      = 8'h03;
   localparam logic [7:0] OP_READ     = 8'h04;
   localparam logic [7:0] OP_STATUS   = 8'h05;
   localparam logic [7:0] OP_ABORT    = 8'h06;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE, S_READOUT} state_t;
   typedef enum logic [1:0] {P_OPC, P_ARG1, P_ARG2} pstate_t;
   typedef enum logic [1:0] {R_ADDR, R_WAIT, R_LATCH, R_SEND} rphase_t;

   state_t            state, state_n;
   pstate_t           pstate, pstate_n;
   rphase_t           rphase;
   logic [7:0]        sync1, sample;
   logic [7:0]        opcode, arg1;
   logic [DIV_W-1:0]  div, div_cnt;
   logic [7:0]        mask, value;
   logic [ADDR_W-1:0] waddr, rd_addr;
   logic [7:0]        rd_data, status_byte;
   logic              triggered, status_pend, load_q;

   logic opc_valid, cmd_arm, cmd_read, cmd_status, cmd_abort, cmd_set_div, cmd_set_trig;
   logic cfg_ok, running, tick, trig_hit, cap_last, ro_send, ro_last;

   // In READOUT only STATUS and ABORT reach the parser; everything else is dropped.
   assign opc_valid    = rx_valid && (pstate == P_OPC) &&
                         (state != S_READOUT || rx_byte == OP_STATUS || rx_byte == OP_ABORT);
   assign cmd_arm      = opc_valid && (rx_byte == OP_ARM);
   assign cmd_read     = opc_valid && (rx_byte == OP_READ);
   assign cmd_status   = opc_valid && (rx_byte == OP_STATUS);
   assign cmd_abort    = opc_valid && (rx_byte == OP_ABORT);
   assign cmd_set_div  = rx_valid && (pstate == P_ARG2) && (opcode == OP_SET_DIV);
   assign cmd_set_trig = rx_valid && (pstate == P_ARG2) && (opcode == OP_SET_TRIG);
   assign cfg_ok       = (state == S_IDLE) || (state == S_DONE);

   assign running  = (state == S_ARMED) || (state == S_CAPTURE);
   assign tick     = running && (div_cnt == div);
   assign trig_hit = tick && (state == S_ARMED) && ((sample & mask) == (value & mask));
   assign cap_last = tick && (state == S_CAPTURE) && (waddr == LAST_ADDR);

   // A queued STATUS byte always goes ahead of the pending sample byte.
   assign tx_load = tx_ready && !load_q &&
                    (status_pend || (state == S_READOUT && rphase == R_SEND));
   assign ro_send = tx_load && !status_pend;
   assign ro_last = ro_send && (rd_addr == LAST_ADDR);
   assign tx_byte = status_pend ? status_byte : rd_data;
   assign mem_raddr = rd_addr;

   always_comb begin
      pstate_n = pstate;
      state_n  = state;
      case (pstate)
         P_OPC:   if (opc_valid && (rx_byte == OP_SET_DIV || rx_byte == OP_SET_TRIG))
                     pstate_n = P_ARG1;
         P_ARG1:  if (rx_valid) pstate_n = P_ARG2;
         P_ARG2:  if (rx_valid) pstate_n = P_OPC;
         default: pstate_n = P_OPC;
      endcase
      // Tick-driven transitions first, then the received command overrides.
      case (state)
         S_IDLE:    if (cmd_arm) state_n = S_ARMED;
         S_ARMED: begin
            if (trig_hit)       state_n = S_CAPTURE;
            if (cmd_abort)      state_n = S_IDLE;
            else if (cmd_arm)   state_n = S_ARMED;
         end
         S_CAPTURE: begin
            if (cap_last)       state_n = S_DONE;
            if (cmd_abort)      state_n = S_IDLE;
            else if (cmd_arm)   state_n = S_ARMED;
         end
         S_DONE: begin
            if (cmd_arm)        state_n = S_ARMED;
            else if (cmd_read)  state_n = S_READOUT;
         end
         S_READOUT: if (ro_last || cmd_abort) state_n = S_DONE;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state  <= S_IDLE;
         pstate <= P_OPC;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         pstate <= pstate_n;
         busy   <= (state_n == S_ARMED) || (state_n == S_CAPTURE) || (state_n == S_READOUT);
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         sync1       <= '0;
         sample      <= '0;
         opcode      <= '0;
         arg1        <= '0;
         div         <= '0;
         div_cnt     <= '0;
         mask        <= '0;
         value       <= '0;
         waddr       <= '0;
         triggered   <= 1'b0;
         mem_we      <= 1'b0;
         mem_waddr   <= '0;
         mem_wdata   <= '0;
         rd_addr     <= '0;
         rd_data     <= '0;
         rphase      <= R_ADDR;
         status_byte <= '0;
         status_pend <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         sync1  <= pin_values;
         sample <= sync1;

         if (opc_valid) opcode <= rx_byte;
         if (rx_valid && pstate == P_ARG1) arg1 <= rx_byte;
         if (cmd_set_div && cfg_ok) div <= DIV_W'({arg1, rx_byte});
         if (cmd_set_trig && cfg_ok) begin
            mask  <= arg1;
            value <= rx_byte;
         end

         mem_we <= tick && (trig_hit || state == S_CAPTURE);
         if (tick) begin
            mem_waddr <= trig_hit ? '0 : waddr;
            mem_wdata <= sample;
         end
         if (tick)         div_cnt <= '0;
         else if (running) div_cnt <= div_cnt + 1'b1;
         else              div_cnt <= '0;
         if (trig_hit) begin
            waddr     <= ADDR_W'(1);
            triggered <= 1'b1;
         end else if (tick && state == S_CAPTURE) begin
            waddr <= waddr + 1'b1;
         end
         // ARM restarts the sequence even when it lands on a tick.
         if (cmd_arm) begin
            div_cnt   <= '0;
            waddr     <= '0;
            triggered <= 1'b0;
         end

         if (state == S_DONE && cmd_read) begin
            rd_addr <= '0;
            rphase  <= R_ADDR;
         end else if (state == S_READOUT) begin
            case (rphase)
               R_ADDR:  rphase <= R_WAIT;
               R_WAIT:  rphase <= R_LATCH;
               R_LATCH: begin
                  rd_data <= mem_rdata;
                  rphase  <= R_SEND;
               end
               default: if (ro_send) begin
                  rd_addr <= rd_addr + 1'b1;
                  rphase  <= R_ADDR;
               end
            endcase
         end

         if (cmd_status) begin
            status_pend <= 1'b1;
            status_byte <= {triggered, 3'b000, state == S_READOUT, state == S_DONE,
                            state == S_CAPTURE, state == S_ARMED};
         end else if (tx_load && status_pend) begin
            status_pend <= 1'b0;
         end
         load_q <= tx_load;
      end
   end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: RAM and SPI-slave models, event logs
// sampled on the falling edge, one task per scenario.
module tb_capture_sequencer;
   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pin_values = 8'h00;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b0;
   logic [7:0] tx_byte;
   logic       tx_load;
   logic       mem_we;
   logic [8:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic [8:0] mem_raddr;
   logic [7:0] mem_rdata;
   logic       busy;

   capture_sequencer #(.ADDR_W(9), .DIV_W(16)) dut (
      .CLK(CLK), .reset(reset), .pin_values(pin_values), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_load(tx_load),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .busy(busy));

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_checks = 0;
   int cyc = 0;
   logic       pin_step = 1'b0;
   logic [7:0] pin_hold = 8'h00;
   logic       slave_rnd = 1'b0;
   logic       last_load = 1'b0;
   logic [7:0] ram [0:511];

   logic [8:0] wr_addr [$];
   logic [7:0] wr_data [$];
   int         wr_cyc  [$];
   logic [7:0] ld_byte [$];
   int         ld_cyc  [$];
   int         ld_bad = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      if (mem_we) ram[mem_waddr] <= mem_wdata;
      mem_rdata <= ram[mem_raddr];
   end

   // Pins: either a free-running count or a held pattern.
   always @(posedge CLK) begin
      #2;
      pin_values = pin_step ? pin_values + 8'd1 : pin_hold;
   end

   // SPI slave: drops tx_ready for the cycle after a load.
   always @(posedge CLK) begin
      #2;
      if (last_load) tx_ready = 1'b0;
      else           tx_ready = slave_rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   always @(negedge CLK) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_waddr);
         wr_data.push_back(mem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (tx_load === 1'b1) begin
         if (tx_ready !== 1'b1) ld_bad++;
         if (ld_cyc.size() > 0 && cyc - ld_cyc[ld_cyc.size()-1] < 2) ld_bad++;
         ld_byte.push_back(tx_byte);
         ld_cyc.push_back(cyc);
      end
      last_load = (tx_load === 1'b1);
   end

   task automatic send(input logic [7:0] b);
      @(posedge CLK); #1;
      rx_byte = b;
      rx_valid = 1'b1;
      @(posedge CLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic clear_logs();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      ld_byte.delete(); ld_cyc.delete();
      ld_bad = 0;
   endtask

   task automatic status_query(output int cnt, output logic [7:0] b);
      ld_byte.delete(); ld_cyc.delete();
      send(8'h05);
      repeat (8) @(negedge CLK);
      cnt = ld_byte.size();
      b = (cnt > 0) ? ld_byte[0] : 8'hxx;
   endtask

   task automatic test_reset();
      int cnt; logic [7:0] b;
      repeat (3) @(posedge CLK);
      #1 reset = 1'b0;
      @(negedge CLK);
      n_checks++; if ({busy, tx_load, mem_we} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, tx_load, mem_we}); else n_pass++;
      n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_byte); else n_pass++;
      n_checks++; if ({mem_waddr, mem_raddr, mem_wdata} !== 26'd0) $display("FAIL reset_mem: got %h want 0", {mem_waddr, mem_raddr, mem_wdata}); else n_pass++;
      status_query(cnt, b);
      n_checks++; if (cnt !== 1) $display("FAIL reset_status_loads: got %0d want 1", cnt); else n_pass++;
      n_checks++; if (b !== 8'h00) $display("FAIL reset_status_byte: got %h want 00", b); else n_pass++;
   endtask

   task automatic test_capture_div0();
      int arm, cnt, aerr, derr, serr; logic [7:0] b;
      pin_step = 1'b1;
      send(8'h02); send(8'h00); send(8'h00);
      clear_logs();
      send(8'h03);
      arm = cyc;
      @(negedge CLK);
      n_checks++; if (busy !== 1'b1) $display("FAIL div0_busy: got %b want 1", busy); else n_pass++;
      for (int i = 0; i < 2000 && wr_addr.size() < 512; i++) @(negedge CLK);
      repeat (20) @(negedge CLK);
      n_checks++; if (wr_addr.size() !== 512) $display("FAIL div0_count: got %0d want 512", wr_addr.size()); else n_pass++;
      if (wr_addr.size() >= 512) begin
         aerr = 0; derr = 0; serr = 0;
         for (int i = 0; i < 512; i++) begin
            if (wr_addr[i] !== 9'(i)) aerr++;
            if (wr_data[i] !== 8'(wr_data[0] + 8'(i))) derr++;
            if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != 1) serr++;
         end
         n_checks++; if (wr_cyc[0] !== arm + 1) $display("FAIL div0_first_latency: got %0d want %0d", wr_cyc[0] - arm, 1); else n_pass++;
         n_checks++; if (aerr !== 0) $display("FAIL div0_addr_seq: got %0d bad want 0", aerr); else n_pass++;
         n_checks++; if (derr !== 0) $display("FAIL div0_data_seq: got %0d bad want 0", derr); else n_pass++;
         n_checks++; if (serr !== 0) $display("FAIL div0_spacing: got %0d bad want 0", serr); else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL div0_done_busy: got %b want 0", busy); else n_pass++;
      pin_step = 1'b0;
      status_query(cnt, b);
      n_checks++; if (cnt !== 1 || b !== 8'h84) $display("FAIL div0_status: got %0d/%h want 1/84", cnt, b); else n_pass++;
   endtask

   task automatic test_readout_random();
      int berr, cnt; logic [7:0] b;
      slave_rnd = 1'b1;
      clear_logs();
      send(8'h04);
      for (int i = 0; i < 20000 && ld_byte.size() < 512; i++) @(negedge CLK);
      repeat (20) @(negedge CLK);
      slave_rnd = 1'b0;
      n_checks++; if (ld_byte.size() !== 512) $display("FAIL rd_rand_count: got %0d want 512", ld_byte.size()); else n_pass++;
      berr = 0;
      for (int i = 0; i < 512 && i < ld_byte.size(); i++) if (ld_byte[i] !== ram[i]) berr++;
      n_checks++; if (berr !== 0) $display("FAIL rd_rand_bytes: got %0d bad want 0", berr); else n_pass++;
      n_checks++; if (ld_bad !== 0) $display("FAIL rd_rand_handshake: got %0d bad want 0", ld_bad); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rd_rand_busy: got %b want 0", busy); else n_pass++;
      status_query(cnt, b);
      n_checks++; if (cnt !== 1 || b !== 8'h84) $display("FAIL rd_rand_status: got %0d/%h want 1/84", cnt, b); else n_pass++;
   endtask

   task automatic test_readout_status();
      int gerr, ri, ins, errs;
      clear_logs();
      send(8'h04);
      for (int i = 0; i < 1000 && ld_byte.size() < 30; i++) @(negedge CLK);
      send(8'h05);
      for (int i = 0; i < 5000 && ld_byte.size() < 513; i++) @(negedge CLK);
      repeat (20) @(negedge CLK);
      n_checks++; if (ld_byte.size() !== 513) $display("FAIL rd_stat_count: got %0d want 513", ld_byte.size()); else n_pass++;
      gerr = 0;
      for (int i = 1; i < 20 && i < ld_cyc.size(); i++) if (ld_cyc[i] - ld_cyc[i-1] != 4) gerr++;
      n_checks++; if (gerr !== 0) $display("FAIL rd_period: got %0d bad gaps want 0", gerr); else n_pass++;
      ri = 0; ins = 0; errs = 0;
      foreach (ld_byte[j]) begin
         if (ri < 512 && ld_byte[j] === ram[ri]) ri++;
         else if (ins == 0 && ld_byte[j] === 8'h88) ins = 1;
         else errs++;
      end
      n_checks++; if (errs !== 0 || ri !== 512 || ins !== 1) $display("FAIL rd_stat_merge: got err=%0d idx=%0d ins=%0d want 0/512/1", errs, ri, ins); else n_pass++;
      n_checks++; if (ld_bad !== 0) $display("FAIL rd_stat_handshake: got %0d bad want 0", ld_bad); else n_pass++;
   endtask

   task automatic test_reset_readout();
      int cnt; logic [7:0] b;
      send(8'h04);
      repeat (20) @(negedge CLK);
      @(posedge CLK); #1 reset = 1'b1;
      @(posedge CLK); #1 reset = 1'b0;
      @(negedge CLK);
      n_checks++; if ({tx_load, busy, mem_we} !== 3'b000) $display("FAIL rst_rd_ctrl: got %b want 000", {tx_load, busy, mem_we}); else n_pass++;
      status_query(cnt, b);
      n_checks++; if (cnt !== 1 || b !== 8'h00) $display("FAIL rst_rd_status: got %0d/%h want 1/00", cnt, b); else n_pass++;
   endtask

   task automatic test_trigger_div3();
      int arm, r, c, serr, cnt; logic [7:0] b;
      pin_hold = 8'h15;
      send(8'h01); send(8'h00); send(8'h03);
      send(8'h02); send(8'h80); send(8'h80);
      clear_logs();
      send(8'h03);
      arm = cyc;
      repeat (50) @(negedge CLK);
      n_checks++; if (wr_addr.size() !== 0) $display("FAIL trig_early_writes: got %0d want 0", wr_addr.size()); else n_pass++;
      @(posedge CLK); #1 pin_hold = 8'h95;
      r = cyc;
      c = arm + 3;
      while (c < r + 2) c += 4;
      for (int i = 0; i < 40 && wr_addr.size() < 1; i++) @(negedge CLK);
      n_checks++; if (wr_addr.size() < 1) $display("FAIL trig_first_write: got none want one"); else n_pass++;
      if (wr_addr.size() >= 1) begin
         n_checks++; if (wr_cyc[0] !== c + 1) $display("FAIL trig_first_cycle: got %0d want %0d", wr_cyc[0], c + 1); else n_pass++;
         n_checks++; if (wr_addr[0] !== 9'd0 || wr_data[0] !== 8'h95) $display("FAIL trig_first_data: got %0d/%h want 0/95", wr_addr[0], wr_data[0]); else n_pass++;
      end
      // Stop the capture right after the write to address 100.
      for (int i = 0; i < 2000 && wr_addr.size() < 101; i++) @(negedge CLK);
      serr = 0;
      for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 4) serr++;
      n_checks++; if (serr !== 0) $display("FAIL trig_spacing: got %0d bad want 0", serr); else n_pass++;
      send(8'h06);
      repeat (40) @(negedge CLK);
      n_checks++; if (wr_addr.size() !== 101) $display("FAIL abort_writes: got %0d want 101", wr_addr.size()); else n_pass++;
      n_checks++; if (wr_addr[wr_addr.size()-1] !== 9'd100) $display("FAIL abort_last_addr: got %0d want 100", wr_addr[wr_addr.size()-1]); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
      status_query(cnt, b);
      n_checks++; if (cnt !== 1 || b !== 8'h80) $display("FAIL abort_status: got %0d/%h want 1/80", cnt, b); else n_pass++;
   endtask

   task automatic test_setdiv_armed();
      int cnt, serr; logic [7:0] b;
      pin_hold = 8'h15;
      repeat (3) @(negedge CLK);
      clear_logs();
      send(8'h03);
      status_query(cnt, b);
      n_checks++; if (cnt !== 1 || b !== 8'h01) $display("FAIL armed_status: got %0d/%h want 1/01", cnt, b); else n_pass++;
      send(8'h01); send(8'h00); send(8'h00);
      @(posedge CLK); #1 pin_hold = 8'h95;
      for (int i = 0; i < 200 && wr_addr.size() < 4; i++) @(negedge CLK);
      serr = (wr_addr.size() < 4) ? 1 : 0;
      for (int i = 1; i < wr_cyc.size(); i++) if (wr_cyc[i] - wr_cyc[i-1] != 4) serr++;
      n_checks++; if (serr !== 0) $display("FAIL armed_div_kept: got %0d bad want 0", serr); else n_pass++;
      send(8'h06);
      repeat (10) @(negedge CLK);
      n_checks++; if (busy !== 1'b0) $display("FAIL armed_abort_busy: got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_capture_div0();
      test_readout_random();
      test_readout_status();
      test_reset_readout();
      test_trigger_div3();
      test_setdiv_armed();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Controller for the 8-channel logic-analyser datapath on the TinyFPGA BX. It decodes command bytes from the SPI slave and sequences the capture itself: sample-rate divider, pattern trigger, and writes of the synchronised pin samples into a single-port-write, single-port-read sample RAM. It also streams the captured buffer back to the host through the SPI transmit register. It sits between the SPI slave, the pin inputs and the sample BRAM inside the main module.

## Interface
- ADDR_W, 9, sample RAM address width; buffer depth is 2^ADDR_W bytes.
- DIV_W, 16, sample divider width.

Ports:
- CLK  in  1  system clock (16 MHz).
- reset  in  1  synchronous, active-high.
- pin_values  in  8  raw probe pins, asynchronous to CLK.
- rx_byte  in  8  received SPI byte.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- tx_ready  in  1  SPI transmit holding register is empty.
- tx_byte  out  8  byte to transmit.
- tx_load  out  1  one-cycle strobe; loads tx_byte.
- mem_we  out  1  sample RAM write enable.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  8  write data.
- mem_raddr  out  ADDR_W  read address.
- mem_rdata  in  8  read data, one cycle after mem_raddr.
- busy  out  1  high in ARMED, CAPTURE and READOUT.

## Operation
- Pins pass through a two-flop synchroniser. The sampled value is the second flop.
- Command parser states are OPC, ARG1 and ARG2. Each rx_valid advances the parser. Opcodes:
  - 0x01 SET_DIV takes 2 args, MSB first. It sets div, zero-extended to DIV_W.
  - 0x02 SET_TRIG takes 2 args: mask, then value.
  - 0x03 ARM.
  - 0x04 READ.
  - 0x05 STATUS.
  - 0x06 ABORT.
  - 0x00 and every other opcode is ignored; the parser stays in OPC.
- SET_DIV and SET_TRIG take effect only in IDLE or DONE. In other states their arguments are still consumed and then discarded.
- Main FSM transitions:
  - IDLE --ARM--> ARMED.
  - DONE --ARM--> ARMED.
  - ARMED --trigger--> CAPTURE.
  - CAPTURE --last write--> DONE.
  - DONE --READ--> READOUT.
  - READOUT --last byte--> DONE.
  - ABORT: from ARMED or CAPTURE go to IDLE; from READOUT go to DONE.
- Sample tick: a DIV_W counter runs in ARMED and CAPTURE and ticks every div+1 cycles.
  - div=0 gives a tick every cycle.
  - The counter clears on ARM, so the first tick is div+1 cycles after the ARM byte.
- Trigger: on a tick in ARMED, when (sample & mask) == (value & mask).
  - mask=0 triggers on the first tick.
  - The triggering sample is written at address 0 in that same cycle.
- CAPTURE writes one sample per tick at addresses 1 up to 2^ADDR_W-1, then enters DONE. Addresses do not wrap.
- READOUT runs in this order:
  - drive mem_raddr;
  - wait one cycle;
  - latch mem_rdata;
  - wait for tx_ready;
  - pulse tx_load;
  - increment the address.
  - After address 2^ADDR_W-1 is sent, go to DONE. Exactly 2^ADDR_W bytes are sent, address 0 first.
- STATUS queues one byte: bit0 ARMED, bit1 CAPTURE, bit2 DONE, bit3 READOUT, bit7 triggered since the last ARM, all other bits 0. The byte is sent on the next cycle with tx_ready high.
  - If STATUS arrives in READOUT, it is sent before the next sample byte.
- In READOUT, every rx byte except ABORT and STATUS is ignored. READ in any state other than DONE is ignored.

## Timing
- Reset values: all outputs 0, div=0, mask=0, value=0, FSM IDLE, parser OPC, triggered flag clear.
- Pin-to-sample latency is 2 cycles. mem_we is registered and is high for exactly one cycle per tick.
- tx_load is asserted only when tx_ready=1. Consecutive tx_load pulses are at least 2 cycles apart. The slave drops tx_ready in the cycle after tx_load.
- With tx_ready held high, the READOUT byte period is 4 cycles.
- When rx_valid and a tick occur in the same cycle, the tick is processed first. ABORT then wins, so the tick's write still happens but no further writes occur.
- ARM received in ARMED or CAPTURE restarts the sequence: the divider clears and the write address resets.
- A reset asserted mid-capture or mid-readout returns every state to the reset values on the next edge. RAM contents are not cleared.
- busy is a registered decode of the FSM state.

## Test plan
- Reset, then STATUS -> tx_byte 0x00 with one tx_load pulse.
- SET_TRIG 0x00 0x00, ARM, pins stepping 0,1,2… per cycle, div=0 -> 512 consecutive writes, addresses 0..511, data contiguous; STATUS returns 0x84.
- SET_DIV 0x00 0x03, SET_TRIG 0x80 0x80, ARM, pin7 raised at cycle 50 -> no writes before the trigger; the first write has addr 0 with bit7=1; write spacing is 4 cycles.
- After capture, READ with tx_ready toggling randomly -> 512 tx_load pulses carrying RAM bytes in address order, then DONE; no tx_load while tx_ready=0.
- ABORT sent mid-CAPTURE at address 100 -> no further mem_we; IDLE; busy=0. SET_DIV sent during ARMED -> div unchanged.
- reset pulsed during READOUT -> tx_load=0, busy=0, and a following STATUS returns 0x00.
